// File: rtl/systolic_result_drain.sv
// Output drain for systolic_array: waits LATENCY edges after start, snapshots the
// accumulator matrix and streams shifted/ReLU'd/saturated elements row-major over valid/ready.
module systolic_result_drain #(
  parameter int N       = 16,
  parameter int AROW    = 4,
  parameter int BCOL    = 4,
  parameter int LATENCY = 10,
  parameter int SHIFT   = 0,
  parameter int RELU    = 0,
  localparam int RW     = (AROW > 1) ? $clog2(AROW) : 1,
  localparam int CW     = (BCOL > 1) ? $clog2(BCOL) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [AROW-1:0][BCOL-1:0][2*N-1:0]   sys_array,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [N-1:0]                         out_data,
  output logic [RW-1:0]                        out_row,
  output logic [CW-1:0]                        out_col,
  output logic                                 out_last,
  output logic                                 busy,
  output logic                                 start_dropped
);

  localparam int WW = $clog2(LATENCY + 1);
  localparam logic signed [2*N-1:0] SMAX = {{(N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [2*N-1:0] SMIN = {{(N+1){1'b1}}, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, WAIT, STREAM} state_t;

  state_t                              state, state_n;
  logic [WW-1:0]                       wait_cnt;
  logic [AROW-1:0][BCOL-1:0][2*N-1:0]  snap;
  logic                                hs, final_hs, capture, launch;
  logic [RW-1:0]                       nr;
  logic [CW-1:0]                       nc;
  logic                                nxt_last;

  function automatic logic [N-1:0] process(input logic [2*N-1:0] acc);
    logic signed [2*N-1:0] s;
    s = $signed(acc) >>> SHIFT;
    if (RELU != 0 && s[2*N-1]) s = '0;
    if (s > SMAX)      s = SMAX;
    else if (s < SMIN) s = SMIN;
    return s[N-1:0];
  endfunction

  always_comb begin
    hs       = out_valid && out_ready;
    final_hs = hs && out_last;
    capture  = (state == WAIT) && (wait_cnt == WW'(LATENCY));
    // A start coinciding with the final handshake is a legal back-to-back launch.
    launch   = start && ((state == IDLE) || final_hs);
    if (out_col == CW'(BCOL - 1)) begin
      nc = '0;
      nr = out_row + 1'b1;
    end else begin
      nc = out_col + 1'b1;
      nr = out_row;
    end
    nxt_last = (nr == RW'(AROW - 1)) && (nc == CW'(BCOL - 1));
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = WAIT;
      WAIT:    if (capture) state_n = STREAM;
      STREAM:  if (final_hs) state_n = start ? WAIT : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt      <= '0;
      snap          <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_row       <= '0;
      out_col       <= '0;
      out_last      <= 1'b0;
      start_dropped <= 1'b0;
    end else begin
      start_dropped <= start && !launch;
      if (launch)
        wait_cnt <= WW'(1);
      else if (state == WAIT && !capture)
        wait_cnt <= wait_cnt + 1'b1;

      if (capture) begin
        snap      <= sys_array;
        out_valid <= 1'b1;
        out_row   <= '0;
        out_col   <= '0;
        out_data  <= process(sys_array[0][0]);
        out_last  <= (AROW == 1) && (BCOL == 1);
      end else if (hs) begin
        if (out_last) begin
          out_valid <= 1'b0;
          out_row   <= '0;
          out_col   <= '0;
          out_last  <= 1'b0;
        end else begin
          out_row  <= nr;
          out_col  <= nc;
          out_data <= process(snap[nr][nc]);
          out_last <= nxt_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain: three instances (plain, SHIFT=2, RELU=1)
// share stimulus; expected elements come from a bench-side matrix product.
module tb_systolic_result_drain;
  localparam int LAT = 10;

  logic clk = 1'b0;
  logic rst, start, out_ready;
  logic [3:0][3:0][31:0] sys_array;
  logic        ov[3];
  logic [15:0] od[3];
  logic [1:0]  orow[3], ocol[3];
  logic        ol[3], ob[3], osd[3];

  int checks = 0;
  int errors = 0;
  int cmat[4][4];
  logic [15:0] e0[16], es[16], er[16];

  always #5 clk = ~clk;

  systolic_result_drain #(.N(16), .AROW(4), .BCOL(4), .LATENCY(LAT), .SHIFT(0), .RELU(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .sys_array(sys_array), .out_valid(ov[0]),
    .out_ready(out_ready), .out_data(od[0]), .out_row(orow[0]), .out_col(ocol[0]),
    .out_last(ol[0]), .busy(ob[0]), .start_dropped(osd[0]));
  systolic_result_drain #(.N(16), .AROW(4), .BCOL(4), .LATENCY(LAT), .SHIFT(2), .RELU(0)) dut_s (
    .clk(clk), .rst(rst), .start(start), .sys_array(sys_array), .out_valid(ov[1]),
    .out_ready(out_ready), .out_data(od[1]), .out_row(orow[1]), .out_col(ocol[1]),
    .out_last(ol[1]), .busy(ob[1]), .start_dropped(osd[1]));
  systolic_result_drain #(.N(16), .AROW(4), .BCOL(4), .LATENCY(LAT), .SHIFT(0), .RELU(1)) dut_r (
    .clk(clk), .rst(rst), .start(start), .sys_array(sys_array), .out_valid(ov[2]),
    .out_ready(out_ready), .out_data(od[2]), .out_row(orow[2]), .out_col(ocol[2]),
    .out_last(ol[2]), .busy(ob[2]), .start_dropped(osd[2]));

  task automatic load_product();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        cmat[i][j] = 0;
        for (int k = 0; k < 4; k++)
          cmat[i][j] += (4 * i + k + 1) * (4 * k + j + 17);
        sys_array[i][j] = cmat[i][j];
        e0[4 * i + j] = cmat[i][j][15:0];
        es[4 * i + j] = 16'(cmat[i][j] / 4);
        er[4 * i + j] = cmat[i][j][15:0];
      end
  endtask

  task automatic launch();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (ob[0] !== 1'b1 || ov[0] !== 1'b0) begin
      errors++;
      $display("FAIL launch: busy=%b valid=%b, required busy=1 valid=0", ob[0], ov[0]);
    end
  endtask

  task automatic wait_valid(input int exp_n);
    int n = 0;
    while (!ov[0] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != exp_n) begin
      errors++;
      $display("FAIL latency: valid after %0d edges, required %0d", n, exp_n);
    end
  endtask

  // pat 0: always ready; pat 1: ready pattern 1,0,0,1. drop_at: beat at which a
  // stray start is pulsed. start_last: pulse start on the final handshake.
  task automatic drain(input int pat, input int drop_at, input bit start_last, input int nb);
    int  beat = 0;
    int  cyc  = 0;
    bit  prev_start = 0;
    bit  drop_done = 0;
    bit  rdy, accepted;
    while (beat < nb && cyc < 400) begin
      rdy = (pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      out_ready = rdy;
      start = 1'b0;
      accepted = 1'b0;
      if (drop_at >= 0 && beat == drop_at && !drop_done) begin
        start = 1'b1;
        drop_done = 1'b1;
      end
      if (start_last && beat == nb - 1 && rdy && ov[0]) begin
        start = 1'b1;
        accepted = 1'b1;
      end
      checks++;
      if (osd[0] !== prev_start) begin
        errors++;
        $display("FAIL start_dropped beat %0d: got %b, required %b", beat, osd[0], prev_start);
      end
      if (ov[0]) begin
        checks += 6;
        if (od[0] !== e0[beat]) begin
          errors++; $display("FAIL data beat %0d: got %h, required %h", beat, od[0], e0[beat]);
        end
        if (od[1] !== es[beat]) begin
          errors++; $display("FAIL shift_data beat %0d: got %h, required %h", beat, od[1], es[beat]);
        end
        if (od[2] !== er[beat]) begin
          errors++; $display("FAIL relu_data beat %0d: got %h, required %h", beat, od[2], er[beat]);
        end
        if (orow[0] !== 2'(beat / 4)) begin
          errors++; $display("FAIL row beat %0d: got %0d, required %0d", beat, orow[0], beat / 4);
        end
        if (ocol[0] !== 2'(beat % 4)) begin
          errors++; $display("FAIL col beat %0d: got %0d, required %0d", beat, ocol[0], beat % 4);
        end
        if (ol[0] !== (beat == 15)) begin
          errors++; $display("FAIL last beat %0d: got %b, required %b", beat, ol[0], beat == 15);
        end
        if (rdy) beat++;
      end
      prev_start = start && !accepted;
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    start = 1'b0;
    checks++;
    if (beat != nb) begin
      errors++;
      $display("FAIL handshakes: got %0d, required %0d (timeout)", beat, nb);
    end
    if (nb == 16) begin
      checks++;
      if (ov[0] !== 1'b0 || ob[0] !== start_last || osd[0] !== 1'b0) begin
        errors++;
        $display("FAIL end_of_stream: valid=%b busy=%b dropped=%b, required valid=0 busy=%b dropped=0",
                 ov[0], ob[0], osd[0], start_last);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; sys_array = '0;
    @(posedge clk); #1;
    checks++;
    if ({ov[0], od[0], orow[0], ocol[0], ol[0], ob[0], osd[0]} !== '0) begin
      errors++;
      $display("FAIL reset: valid=%b data=%h row=%0d col=%0d last=%b busy=%b dropped=%b, required all 0",
               ov[0], od[0], orow[0], ocol[0], ol[0], ob[0], osd[0]);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    load_product();
    launch();
    wait_valid(LAT);
    sys_array = '1;
    drain(0, -1, 1'b0, 16);
  endtask

  task automatic test_backpressure();
    load_product();
    launch();
    wait_valid(LAT);
    sys_array = '0;
    drain(1, -1, 1'b0, 16);
  endtask

  task automatic test_saturation();
    sys_array = '0;
    for (int i = 0; i < 16; i++) begin
      e0[i] = 16'h0000; es[i] = 16'h0000; er[i] = 16'h0000;
    end
    sys_array[0][0] = 32'h0001_0000; e0[0] = 16'h7FFF; es[0] = 16'h4000; er[0] = 16'h7FFF;
    sys_array[0][1] = -32'sd5;       e0[1] = 16'hFFFB; es[1] = 16'hFFFE; er[1] = 16'h0000;
    sys_array[0][2] = 32'h8000_0000; e0[2] = 16'h8000; es[2] = 16'h8000; er[2] = 16'h0000;
    sys_array[0][3] = -32'sd40000;   e0[3] = 16'h8000; es[3] = 16'hD8F0; er[3] = 16'h0000;
    sys_array[1][0] = 32'h0000_7FFF; e0[4] = 16'h7FFF; es[4] = 16'h1FFF; er[4] = 16'h7FFF;
    launch();
    wait_valid(LAT);
    drain(0, -1, 1'b0, 16);
  endtask

  task automatic test_back_to_back();
    load_product();
    launch();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (osd[0] !== 1'b1) begin
      errors++; $display("FAIL wait_drop: got %b, required 1", osd[0]);
    end
    @(posedge clk); #1;
    checks++;
    if (osd[0] !== 1'b0) begin
      errors++; $display("FAIL wait_drop_pulse: got %b, required 0", osd[0]);
    end
    wait_valid(LAT - 3);
    drain(0, 5, 1'b1, 16);
    wait_valid(LAT);
    drain(0, -1, 1'b0, 16);
  endtask

  task automatic test_reset_mid();
    load_product();
    launch();
    wait_valid(LAT);
    drain(0, -1, 1'b0, 5);
    rst = 1'b1;
    #1;
    checks++;
    if ({ov[0], od[0], orow[0], ocol[0], ol[0], ob[0]} !== '0) begin
      errors++;
      $display("FAIL async_reset: valid=%b data=%h row=%0d col=%0d last=%b busy=%b, required all 0",
               ov[0], od[0], orow[0], ocol[0], ol[0], ob[0]);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ov[0] !== 1'b0 || ob[0] !== 1'b0) begin
        errors++; $display("FAIL idle_after_reset: valid=%b busy=%b, required 0 0", ov[0], ob[0]);
      end
    end
    launch();
    wait_valid(LAT);
    drain(0, -1, 1'b0, 16);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
